// File: rtl/morse_decoder_if.sv
// morse_decoder_if: keyed-signal input and decoded-letter outputs of the Morse receiver.
interface morse_decoder_if;
    logic       i_in;
    logic [4:0] o_letter;
    logic [6:0] o_display;
    logic       o_done;
    modport master (output i_in, input o_letter, o_display, o_done);
    modport slave (input i_in, output o_letter, o_display, o_done);
endinterface

// File: rtl/morse_decoder.sv
// morse_decoder: serial Morse receiver classifying marks as dots/dashes and decoding A-Z letters.
// Define MORSE_SEVSEG_EN to compile in the 7-segment glyph table driving o_display.
module morse_decoder #(
    parameter int UNIT  = 1,
    parameter int CNT_W = 16
) (
    input logic            clk,
    input logic            rst_n,
    morse_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
    localparam logic [CNT_W:0] TWO_U = (CNT_W+1)'(2 * UNIT);
    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_mark_cnt, w_mark_cnt, r_space_cnt, w_space_cnt;
    logic [CNT_W-1:0] w_mark_inc, w_space_inc;
    logic [3:0]       r_code, w_code;
    logic [2:0]       r_len, w_len;
    logic [4:0]       r_letter, w_dec_letter;
    logic             r_done, w_done, w_valid, w_hit, w_dash;
    assign w_mark_inc  = (r_mark_cnt == '1) ? r_mark_cnt : r_mark_cnt + 1'b1;
    assign w_space_inc = (r_space_cnt == '1) ? r_space_cnt : r_space_cnt + 1'b1;
    assign w_dash      = {1'b0, r_mark_cnt} >= TWO_U;
    // code holds the symbols right-aligned, first symbol in the highest used bit
    always_comb begin
        w_hit        = 1'b1;
        w_dec_letter = 5'd0;
        case ({r_len, r_code})
            {3'd2, 4'b0001}: w_dec_letter = 5'd0;
            {3'd4, 4'b1000}: w_dec_letter = 5'd1;
            {3'd4, 4'b1010}: w_dec_letter = 5'd2;
            {3'd3, 4'b0100}: w_dec_letter = 5'd3;
            {3'd1, 4'b0000}: w_dec_letter = 5'd4;
            {3'd4, 4'b0010}: w_dec_letter = 5'd5;
            {3'd3, 4'b0110}: w_dec_letter = 5'd6;
            {3'd4, 4'b0000}: w_dec_letter = 5'd7;
            {3'd2, 4'b0000}: w_dec_letter = 5'd8;
            {3'd4, 4'b0111}: w_dec_letter = 5'd9;
            {3'd3, 4'b0101}: w_dec_letter = 5'd10;
            {3'd4, 4'b0100}: w_dec_letter = 5'd11;
            {3'd2, 4'b0011}: w_dec_letter = 5'd12;
            {3'd2, 4'b0010}: w_dec_letter = 5'd13;
            {3'd3, 4'b0111}: w_dec_letter = 5'd14;
            {3'd4, 4'b0110}: w_dec_letter = 5'd15;
            {3'd4, 4'b1101}: w_dec_letter = 5'd16;
            {3'd3, 4'b0010}: w_dec_letter = 5'd17;
            {3'd3, 4'b0000}: w_dec_letter = 5'd18;
            {3'd1, 4'b0001}: w_dec_letter = 5'd19;
            {3'd3, 4'b0001}: w_dec_letter = 5'd20;
            {3'd4, 4'b0001}: w_dec_letter = 5'd21;
            {3'd3, 4'b0011}: w_dec_letter = 5'd22;
            {3'd4, 4'b1001}: w_dec_letter = 5'd23;
            {3'd4, 4'b1011}: w_dec_letter = 5'd24;
            {3'd4, 4'b1100}: w_dec_letter = 5'd25;
            default:         w_hit        = 1'b0;
        endcase
    end
    always_comb begin
        w_state     = r_state;
        w_mark_cnt  = r_mark_cnt;
        w_space_cnt = r_space_cnt;
        w_code      = r_code;
        w_len       = r_len;
        w_valid     = 1'b0;
        w_done      = bus.i_in ? 1'b0 : r_done;
        case (r_state)
            IDLE: begin
                if (bus.i_in) begin
                    w_state    = MARK;
                    w_mark_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            MARK: begin
                if (bus.i_in) begin
                    w_mark_cnt = w_mark_inc;
                end else begin
                    w_code      = {r_code[2:0], w_dash};
                    w_len       = (r_len == 3'd5) ? r_len : r_len + 3'd1;
                    w_state     = SPACE;
                    w_space_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            SPACE: begin
                if (bus.i_in) begin
                    w_state    = MARK;
                    w_mark_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if ({1'b0, w_space_inc} >= TWO_U) begin
                    w_state     = IDLE;
                    w_space_cnt = '0;
                    w_code      = '0;
                    w_len       = '0;
                    w_valid     = w_hit;
                    w_done      = w_hit | r_done;
                end else begin
                    w_space_cnt = w_space_inc;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mark_cnt  <= '0;
            r_space_cnt <= '0;
            r_code      <= '0;
            r_len       <= '0;
            r_letter    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_mark_cnt  <= w_mark_cnt;
            r_space_cnt <= w_space_cnt;
            r_code      <= w_code;
            r_len       <= w_len;
            r_letter    <= w_valid ? w_dec_letter : r_letter;
            r_done      <= w_done;
        end
    end
    assign bus.o_letter = r_letter;
    assign bus.o_done   = r_done;
`ifdef MORSE_SEVSEG_EN
    logic [6:0] r_display, w_glyph;
    always_comb begin
        w_glyph = 7'h00;
        case (w_dec_letter)
            5'd0:  w_glyph = 7'h77;
            5'd1:  w_glyph = 7'h7C;
            5'd2:  w_glyph = 7'h39;
            5'd3:  w_glyph = 7'h5E;
            5'd4:  w_glyph = 7'h79;
            5'd5:  w_glyph = 7'h71;
            5'd6:  w_glyph = 7'h3D;
            5'd7:  w_glyph = 7'h76;
            5'd8:  w_glyph = 7'h30;
            5'd9:  w_glyph = 7'h1E;
            5'd10: w_glyph = 7'h75;
            5'd11: w_glyph = 7'h38;
            5'd12: w_glyph = 7'h15;
            5'd13: w_glyph = 7'h54;
            5'd14: w_glyph = 7'h3F;
            5'd15: w_glyph = 7'h73;
            5'd16: w_glyph = 7'h67;
            5'd17: w_glyph = 7'h50;
            5'd18: w_glyph = 7'h6D;
            5'd19: w_glyph = 7'h78;
            5'd20: w_glyph = 7'h3E;
            5'd21: w_glyph = 7'h1C;
            5'd22: w_glyph = 7'h2A;
            5'd23: w_glyph = 7'h76;
            5'd24: w_glyph = 7'h6E;
            5'd25: w_glyph = 7'h5B;
            default: w_glyph = 7'h00;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_display <= 7'h00;
        else        r_display <= w_valid ? w_glyph : r_display;
    end
    assign bus.o_display = r_display;
`else
    assign bus.o_display = 7'h00;
`endif
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed Morse sequences with hand-computed letters and glyphs, UNIT=1.
module tb_morse_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    morse_decoder_if bus();
    morse_decoder #(.UNIT(1), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
`ifdef MORSE_SEVSEG_EN
    localparam bit SEG = 1'b1;
`else
    localparam bit SEG = 1'b0;
`endif
    function automatic logic [6:0] gl(input logic [6:0] g);
        return SEG ? g : 7'h00;
    endfunction
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic d, input logic [4:0] l, input logic [6:0] g);
        chk({tag, ".done"}, {7'd0, bus.o_done}, {7'd0, d});
        chk({tag, ".letter"}, {3'd0, bus.o_letter}, {3'd0, l});
        chk({tag, ".display"}, {1'b0, bus.o_display}, {1'b0, gl(g)});
    endtask
    task automatic send(input logic b);
        bus.i_in = b;
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.i_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 5'd0, 7'h00);
        rst_n = 1'b1;
        // A: .-
        send(1); send(0); send(1); send(1); send(1); send(0);
        chk("A_pre.done", {7'd0, bus.o_done}, 8'd0);
        send(0);
        chk_out("A", 1'b1, 5'd0, 7'h77);
        // B: -...
        send(1);
        chk("B_clr.done", {7'd0, bus.o_done}, 8'd0);
        chk("B_hold.letter", {3'd0, bus.o_letter}, 8'd0);
        send(1); send(0); send(1); send(0); send(1); send(0); send(1); send(0); send(0);
        chk_out("B", 1'b1, 5'd1, 7'h7C);
        // E then a long space: done held throughout
        send(1);
        send(0);
        chk("E_pre.done", {7'd0, bus.o_done}, 8'd0);
        for (int i = 1; i < 50; i++) begin
            send(0);
            chk("E_hold.done", {7'd0, bus.o_done}, 8'd1);
        end
        chk_out("E", 1'b1, 5'd4, 7'h79);
        // five dots: len overflow, no decode
        send(1);
        chk("E_drop.done", {7'd0, bus.o_done}, 8'd0);
        send(0);
        for (int i = 0; i < 4; i++) begin
            send(1); send(0);
        end
        for (int i = 0; i < 50; i++) send(0);
        chk_out("five_dots", 1'b0, 5'd4, 7'h79);
        // ..-- is unassigned
        send(1); send(0); send(1); send(0); send(1); send(1); send(0); send(1); send(1); send(0); send(0);
        chk_out("udd", 1'b0, 5'd4, 7'h79);
        send(1); send(1); send(0); send(0);
        chk_out("T", 1'b1, 5'd19, 7'h78);
        // asynchronous reset mid-letter
        send(1); send(0); send(1); send(1);
        rst_n = 1'b0;
        #2;
        chk_out("async_rst", 1'b0, 5'd0, 7'h00);
        #1;
        rst_n = 1'b1;
        send(1); send(1); send(1); send(0);
        chk_out("T2_pre", 1'b0, 5'd0, 7'h00);
        send(0);
        chk_out("T2", 1'b1, 5'd19, 7'h78);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
